// File: rtl/frame_if_pkg.sv
// Shared definitions for the image buffer DDR read and write paths.
// Address step, beat size and the common frame FSM state encoding.
package frame_if_pkg;

    localparam logic [28:0] ADDR_INC   = 29'd8;
    localparam logic [23:0] BEAT_BYTES = 24'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2
    } frame_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with flush and occupancy count.
// A push into a full FIFO is dropped; flush wins over push and pop.
module sync_fifo_fwft #(
    parameter int W     = 128,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset_clk_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_clk_n) begin
        if (!reset_clk_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_wr_if.sv
// Image buffer write path: packs 32-bit pixels into 128-bit words,
// stages them in a FIFO and issues one-beat writes to the memory arbiter.
module frame_wr_if
    import frame_if_pkg::*;
#(
    parameter int FIFO_DEPTH = 256,
    parameter int FIFO_AW    = 8
) (
    input  logic               clk,
    input  logic               reset_clk_n,
    input  logic               frame_start,
    input  logic               frame_abort,
    input  logic [28:0]        frame_addr,
    input  logic [23:0]        frame_count,
    input  logic [31:0]        pix_data,
    input  logic               pix_valid,
    output logic               mem_wr_req,
    output logic [28:0]        mem_wr_addr,
    output logic [127:0]       mem_wr_data,
    input  logic               mem_wr_ack,
    output logic               frame_busy,
    output logic               frame_done,
    output logic [FIFO_AW:0]   ib_count,
    output logic               overflow
);

    frame_state_t     state, state_n;
    logic             req_q, req_n;
    logic             done_q, done_n;
    logic             pop, latch, beat, accept;
    logic [28:0]      addr_q;
    logic [23:0]      wr_bytes, in_bytes, frame_bytes;
    logic [1:0]       phase;
    logic [95:0]      pack_buf;
    logic             push_pend;
    logic [127:0]     push_data;
    logic             ovf_q;
    logic             fifo_empty, fifo_full;
    logic [FIFO_AW:0] fifo_cnt;
    logic [127:0]     fifo_head;
    logic             unused_frame_lsb;

    assign frame_bytes      = {frame_count[23:4], 4'h0};
    assign unused_frame_lsb = ^frame_count[3:0];
    assign accept = pix_valid && (state != IDLE) && (in_bytes != '0) && !frame_abort;

    sync_fifo_fwft #(
        .W     (128),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk         (clk),
        .reset_clk_n (reset_clk_n),
        .flush       (frame_abort),
        .push        (push_pend),
        .din         (push_data),
        .pop         (pop),
        .dout        (fifo_head),
        .count       (fifo_cnt),
        .empty       (fifo_empty),
        .full        (fifo_full)
    );

    always_comb begin
        state_n = state;
        req_n   = req_q;
        done_n  = 1'b0;
        pop     = 1'b0;
        latch   = 1'b0;
        beat    = 1'b0;
        if (frame_abort) begin
            // an ack coinciding with abort still counts as a written beat
            beat    = req_q && mem_wr_ack;
            state_n = IDLE;
            req_n   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        latch = 1'b1;
                        if (frame_count[23:4] == '0) done_n  = 1'b1;
                        else                         state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (!fifo_empty && wr_bytes != '0) begin
                        req_n   = 1'b1;
                        state_n = REQ;
                    end
                end
                REQ: begin
                    if (mem_wr_ack) begin
                        beat = 1'b1;
                        pop  = 1'b1;
                        if (wr_bytes == BEAT_BYTES) begin
                            req_n   = 1'b0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else if (fifo_cnt >= (FIFO_AW + 1)'(2)) begin
                            req_n = 1'b1;
                        end else begin
                            req_n   = 1'b0;
                            state_n = WAIT;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_clk_n) begin
        if (!reset_clk_n) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            req_q  <= req_n;
            done_q <= done_n;
        end
    end

    always_ff @(posedge clk or negedge reset_clk_n) begin
        if (!reset_clk_n) begin
            addr_q   <= '0;
            wr_bytes <= '0;
        end else if (latch) begin
            addr_q   <= frame_addr;
            wr_bytes <= frame_bytes;
        end else if (beat) begin
            addr_q   <= addr_q + ADDR_INC;
            wr_bytes <= wr_bytes - BEAT_BYTES;
        end
    end

    // Packer: the fourth word registers the full line, pushed a cycle later
    always_ff @(posedge clk or negedge reset_clk_n) begin
        if (!reset_clk_n) begin
            phase     <= '0;
            pack_buf  <= '0;
            push_pend <= 1'b0;
            push_data <= '0;
            in_bytes  <= '0;
            ovf_q     <= 1'b0;
        end else if (frame_abort) begin
            phase     <= '0;
            push_pend <= 1'b0;
            in_bytes  <= '0;
        end else if (latch) begin
            phase     <= '0;
            push_pend <= 1'b0;
            in_bytes  <= frame_bytes;
            ovf_q     <= 1'b0;
        end else begin
            push_pend <= accept && (phase == 2'd3);
            if (push_pend && fifo_full) ovf_q <= 1'b1;
            if (accept) begin
                in_bytes <= in_bytes - 24'd4;
                phase    <= phase + 1'b1;
                case (phase)
                    2'd0:    pack_buf[31:0]  <= pix_data;
                    2'd1:    pack_buf[63:32] <= pix_data;
                    2'd2:    pack_buf[95:64] <= pix_data;
                    default: push_data       <= {pix_data, pack_buf};
                endcase
            end
        end
    end

    assign mem_wr_req  = req_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = fifo_empty ? '0 : fifo_head;
    assign frame_busy  = (state != IDLE);
    assign frame_done  = done_q;
    assign ib_count    = fifo_cnt;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_frame_wr_if.sv
// Scoreboard bench for frame_wr_if: a pixel model predicts each write beat,
// and a simple arbiter model acknowledges requests and checks them.
module tb_frame_wr_if;

    logic         clk = 1'b0;
    logic         reset_clk_n;
    logic         frame_start;
    logic         frame_abort;
    logic [28:0]  frame_addr;
    logic [23:0]  frame_count;
    logic [31:0]  pix_data;
    logic         pix_valid;
    logic         mem_wr_req;
    logic [28:0]  mem_wr_addr;
    logic [127:0] mem_wr_data;
    logic         mem_wr_ack;
    logic         frame_busy;
    logic         frame_done;
    logic [8:0]   ib_count;
    logic         overflow;

    typedef struct packed {
        logic [28:0]  a;
        logic [127:0] d;
    } beat_t;

    beat_t       sb[$];
    logic [28:0] seen_addr[$];
    int          checks = 0;
    int          failures = 0;
    int          m_left, m_phase;
    logic [127:0] m_buf;
    logic [28:0] m_addr;
    int          beats, dones, max_ib, req_age, pix_left;

    always #5 clk = ~clk;

    frame_wr_if dut (
        .clk         (clk),
        .reset_clk_n (reset_clk_n),
        .frame_start (frame_start),
        .frame_abort (frame_abort),
        .frame_addr  (frame_addr),
        .frame_count (frame_count),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ack  (mem_wr_ack),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .ib_count    (ib_count),
        .overflow    (overflow)
    );

    task automatic model_start(input logic [28:0] a, input logic [23:0] c);
        m_addr  = a;
        m_left  = int'(c[23:4]) * 4;
        m_phase = 0;
        m_buf   = '0;
        sb.delete();
        seen_addr.delete();
        beats   = 0;
        dones   = 0;
        max_ib  = 0;
        req_age = 0;
    endtask

    task automatic model_pix(input logic [31:0] p);
        if (m_left > 0) begin
            m_left--;
            m_buf[32*m_phase +: 32] = p;
            m_phase++;
            if (m_phase == 4) begin
                sb.push_back({m_addr, m_buf});
                m_addr  = m_addr + 29'd8;
                m_phase = 0;
            end
        end
    endtask

    task automatic start_frame(input logic [28:0] a, input logic [23:0] c);
        frame_addr  = a;
        frame_count = c;
        frame_start = 1'b1;
        model_start(a, c);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic step(input bit ack_en, input int ack_delay, input int abort_beat);
        beat_t e;
        if (frame_done) dones++;
        if (int'(ib_count) > max_ib) max_ib = int'(ib_count);
        if (mem_wr_req) begin
            req_age++;
            if (ack_en && req_age > ack_delay) begin
                mem_wr_ack = 1'b1;
                req_age    = 0;
                beats++;
                seen_addr.push_back(mem_wr_addr);
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected addr=%h data=%h expected none",
                             mem_wr_addr, mem_wr_data);
                end else begin
                    e = sb.pop_front();
                    if ({mem_wr_addr, mem_wr_data} !== e) begin
                        failures++;
                        $display("FAIL beat got addr=%h data=%h expected addr=%h data=%h",
                                 mem_wr_addr, mem_wr_data, e.a, e.d);
                    end
                end
                if (beats == abort_beat) begin
                    frame_abort = 1'b1;
                    pix_left    = 0;
                    m_left      = 0;
                    m_phase     = 0;
                    sb.delete();
                end
            end
        end else begin
            req_age = 0;
        end
        if (pix_left > 0 && !frame_abort) begin
            pix_data  = $urandom;
            pix_valid = 1'b1;
            pix_left--;
            model_pix(pix_data);
        end
        @(negedge clk);
        pix_valid   = 1'b0;
        mem_wr_ack  = 1'b0;
        frame_abort = 1'b0;
    endtask

    task automatic run(input bit ack_en, input int ack_delay, input int abort_beat,
                       input int max_cycles);
        int extra = 0;
        for (int i = 0; i < max_cycles; i++) begin
            step(ack_en, ack_delay, abort_beat);
            if (dones > 0 && pix_left == 0) begin
                extra++;
                if (extra > 4) break;
            end
        end
    endtask

    task automatic test_reset();
        reset_clk_n = 1'b0;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        frame_addr  = '0;
        frame_count = '0;
        pix_data    = '0;
        pix_valid   = 1'b0;
        mem_wr_ack  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_wr_req, frame_busy, frame_done, overflow} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got %b expected 0000",
                     {mem_wr_req, frame_busy, frame_done, overflow});
        end
        checks++;
        if (ib_count !== 9'd0 || mem_wr_addr !== 29'd0) begin
            failures++;
            $display("FAIL reset_count_addr got ib=%0d addr=%h expected 0 0",
                     ib_count, mem_wr_addr);
        end
        checks++;
        if (mem_wr_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_data got %h expected 0", mem_wr_data);
        end
        reset_clk_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        start_frame(29'h900, 24'h00000F);
        checks++;
        if (frame_done !== 1'b1 || frame_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_count got done=%b busy=%b expected 1 0",
                     frame_done, frame_busy);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_count_pulse got done=%b expected 0", frame_done);
        end
    endtask

    task automatic test_basic();
        start_frame(29'h100, 24'd64);
        pix_left = 16;
        run(1'b1, 1, 0, 200);
        checks++;
        if (beats != 4 || dones != 1 || sb.size() != 0) begin
            failures++;
            $display("FAIL basic got beats=%0d dones=%0d left=%0d expected 4 1 0",
                     beats, dones, sb.size());
        end
        checks++;
        if (seen_addr.size() != 4 || seen_addr[3] !== 29'h118) begin
            failures++;
            $display("FAIL basic_last_addr got n=%0d expected 4 beats ending at 118",
                     seen_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        start_frame(29'h4000, 24'd4096);
        pix_left = 1024;
        run(1'b1, 0, 0, 3000);
        checks++;
        if (beats != 256 || dones != 1) begin
            failures++;
            $display("FAIL b2b got beats=%0d dones=%0d expected 256 1", beats, dones);
        end
        checks++;
        if (max_ib > 2) begin
            failures++;
            $display("FAIL b2b_occupancy got max=%0d expected <=2", max_ib);
        end
    endtask

    task automatic test_overflow();
        start_frame(29'h8000, 24'd8192);
        pix_left = 1100;
        run(1'b0, 0, 0, 1110);
        checks++;
        if (ib_count !== 9'd256 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_fill got ib=%0d ovf=%b expected 256 1", ib_count, overflow);
        end
        checks++;
        if (mem_wr_req !== 1'b1 || frame_busy !== 1'b1 || dones != 0) begin
            failures++;
            $display("FAIL ovf_stall got req=%b busy=%b dones=%0d expected 1 1 0",
                     mem_wr_req, frame_busy, dones);
        end
        frame_abort = 1'b1;
        @(negedge clk);
        frame_abort = 1'b0;
        sb.delete();
        checks++;
        if (ib_count !== 9'd0 || mem_wr_req !== 1'b0 || frame_busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_abort got ib=%0d req=%b busy=%b expected 0 0 0",
                     ib_count, mem_wr_req, frame_busy);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got %b expected 1", overflow);
        end
    endtask

    task automatic test_wrap();
        start_frame(29'h1FFFFFF8, 24'd32);
        pix_left = 8;
        run(1'b1, 0, 0, 200);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_ovf_clear got %b expected 0", overflow);
        end
        checks++;
        if (beats != 2 || dones != 1 || seen_addr.size() != 2) begin
            failures++;
            $display("FAIL wrap got beats=%0d dones=%0d expected 2 1", beats, dones);
        end else if (seen_addr[0] !== 29'h1FFFFFF8 || seen_addr[1] !== 29'h0) begin
            failures++;
            $display("FAIL wrap_addr got %h %h expected 1ffffff8 00000000",
                     seen_addr[0], seen_addr[1]);
        end
    endtask

    task automatic test_abort_ack();
        start_frame(29'h3000, 24'd64);
        pix_left = 16;
        run(1'b1, 0, 2, 60);
        checks++;
        if (beats != 2 || dones != 0) begin
            failures++;
            $display("FAIL abort_ack got beats=%0d dones=%0d expected 2 0", beats, dones);
        end
        checks++;
        if (frame_busy !== 1'b0 || mem_wr_req !== 1'b0 || ib_count !== 9'd0) begin
            failures++;
            $display("FAIL abort_idle got busy=%b req=%b ib=%0d expected 0 0 0",
                     frame_busy, mem_wr_req, ib_count);
        end
        start_frame(29'h5000, 24'd32);
        pix_left = 8;
        run(1'b1, 0, 0, 200);
        checks++;
        if (beats != 2 || dones != 1 || seen_addr.size() == 0) begin
            failures++;
            $display("FAIL abort_next got beats=%0d dones=%0d expected 2 1", beats, dones);
        end else if (seen_addr[0] !== 29'h5000) begin
            failures++;
            $display("FAIL abort_next_addr got %h expected 5000", seen_addr[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit got_req = 1'b0;
        start_frame(29'h6000, 24'd64);
        pix_left = 4;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 0, 0);
            if (mem_wr_req) begin
                got_req = 1'b1;
                break;
            end
        end
        checks++;
        if (!got_req) begin
            failures++;
            $display("FAIL rst_mid_req got no request within 50 cycles expected req=1");
        end
        reset_clk_n = 1'b0;
        #1;
        checks++;
        if (mem_wr_req !== 1'b0 || frame_busy !== 1'b0 || ib_count !== 9'd0) begin
            failures++;
            $display("FAIL rst_mid got req=%b busy=%b ib=%0d expected 0 0 0",
                     mem_wr_req, frame_busy, ib_count);
        end
        @(negedge clk);
        reset_clk_n = 1'b1;
        @(negedge clk);
        start_frame(29'h7000, 24'd20);
        pix_left = 10;
        run(1'b1, 0, 0, 200);
        checks++;
        if (beats != 1 || dones != 1 || sb.size() != 0 || ib_count !== 9'd0) begin
            failures++;
            $display("FAIL rst_count20 got beats=%0d dones=%0d ib=%0d expected 1 1 0",
                     beats, dones, ib_count);
        end
    endtask

    initial begin
        test_reset();
        test_zero_count();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_abort_ack();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
